bcd2bin: RTL and testbench

BCD2BIN -- requirements
Module: bcd2bin

---
 rtl/bcd2bin_if.sv | 24 ++
 rtl/bcd2bin.sv | 113 +++++++++++
 tb/tb_bcd2bin.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_if.sv
// Bus bundle for the 4-digit BCD to 14-bit binary converter.
// The testbench drives the master side and the converter uses the slave side.
interface bcd2bin_if;
  logic        start;
  logic [3:0]  bcd3;
  logic [3:0]  bcd2;
  logic [3:0]  bcd1;
  logic [3:0]  bcd0;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  state;

  modport master (
    output start, bcd3, bcd2, bcd1, bcd0,
    input  bin, busy, done, err, state
  );

  modport slave (
    input  start, bcd3, bcd2, bcd1, bcd0,
    output bin, busy, done, err, state
  );
endinterface

// File: rtl/bcd2bin.sv
// Serial 4-digit BCD to 14-bit binary converter using reverse double-dabble.
// Valid requests take 14 SHIFT cycles; requests with a digit above 9 finish at once with err set.
module bcd2bin (
  input  logic       clk,
  input  logic       rst,
  bcd2bin_if.slave   bus
);

  // Handshake: start is sampled only in IDLE; a sampled start launches one conversion.
  // done pulses for exactly one cycle when the result lands; bin/err then hold until the next done.
  // busy is high for every SHIFT cycle. No request queuing: start outside IDLE is dropped.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] bcd_q;
  logic [13:0] work_q;
  logic [3:0]  cnt_q;
  logic [13:0] bin_q;
  logic        err_q;

  logic [15:0] bcd_in;
  logic        bad_digit;
  logic        accept;
  logic        last_step;
  logic [29:0] shifted;
  logic [15:0] bcd_fix;
  logic [3:0]  nib;

  assign bcd_in    = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  assign bad_digit = (bus.bcd3 > 4'd9) || (bus.bcd2 > 4'd9) ||
                     (bus.bcd1 > 4'd9) || (bus.bcd0 > 4'd9);
  assign accept    = (state_q == IDLE) && bus.start;
  assign last_step = (cnt_q == 4'd13);

  // One reverse double-dabble step: shift right, then pull every nibble >= 8 back by 3.
  always_comb begin
    shifted = {bcd_q, work_q} >> 1;
    bcd_fix = '0;
    nib     = '0;
    for (int i = 0; i < 4; i++) begin
      nib = shifted[14 + 4*i +: 4];
      bcd_fix[4*i +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = bad_digit ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q == SHIFT);
    bus.done  = (state_q == DONE);
    bus.state = state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q  <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      bin_q  <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      bcd_q  <= bcd_in;
      work_q <= '0;
      cnt_q  <= '0;
      if (bad_digit) begin
        bin_q <= '0;
        err_q <= 1'b1;
      end
    end else if (state_q == SHIFT) begin
      bcd_q  <= bcd_fix;
      work_q <= shifted[13:0];
      cnt_q  <= cnt_q + 4'd1;
      if (last_step) begin
        bin_q <= shifted[13:0];
        err_q <= 1'b0;
      end
    end
  end

  assign bus.bin = bin_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Directed plus randomized bench for bcd2bin against a decimal-arithmetic reference.
module tb_bcd2bin;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bcd2bin_if bus ();

  bcd2bin dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request and watch a 17-cycle window; cycle c is the c-th cycle after the accepting edge.
  task automatic run_conv(input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0,
                          input bit disturb);
    bit          bad;
    int          exp_val;
    int          n_done;
    int          n_busy;
    int          first_done;
    bit          bin_moved;
    logic [13:0] prev_bin;
    bad     = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
    exp_val = bad ? 0 : (1000 * int'(d3) + 100 * int'(d2) + 10 * int'(d1) + int'(d0));
    bus.bcd3  = d3;
    bus.bcd2  = d2;
    bus.bcd1  = d1;
    bus.bcd0  = d0;
    bus.start = 1'b1;
    prev_bin  = bus.bin;
    n_done = 0; n_busy = 0; first_done = 0; bin_moved = 0;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.start = 1'b0;
      if (disturb && !bad && c == 5) begin
        bus.start = 1'b1;
        bus.bcd3 = 4'($urandom_range(0, 15));
        bus.bcd2 = 4'($urandom_range(0, 15));
        bus.bcd1 = 4'($urandom_range(0, 15));
        bus.bcd0 = 4'($urandom_range(0, 15));
      end
      if (disturb && !bad && c == 6) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (bus.busy === 1'b1) n_busy++;
      if (first_done == 0 && bus.bin !== prev_bin) bin_moved = 1;
    end
    chk("done_cycle", 32'(first_done), bad ? 32'd1 : 32'd15);
    chk("done_count", 32'(n_done), 32'd1);
    chk("busy_cycles", 32'(n_busy), bad ? 32'd0 : 32'd14);
    chk("bin", 32'(bus.bin), 32'(exp_val));
    chk("err", 32'(bus.err), 32'(bad));
    chk("bin_stable", 32'(bin_moved), 32'd0);
  endtask

  initial begin
    int v;
    int n_done;
    logic [3:0] d [4];
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.bcd3 = '0; bus.bcd2 = '0; bus.bcd1 = '0; bus.bcd0 = '0;
    rst = 1'b0;
    #12;
    chk("rst_bin", 32'(bus.bin), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases
    run_conv(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    run_conv(4'd0, 4'd1, 4'd2, 4'd7, 1'b0);
    run_conv(4'd0, 4'd0, 4'hA, 4'd0, 1'b0);
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
    run_conv(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);

    // Reset in the middle of a conversion of 9876
    bus.bcd3 = 4'd9; bus.bcd2 = 4'd8; bus.bcd1 = 4'd7; bus.bcd0 = 4'd6;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_done = 0;
    for (int c = 2; c <= 7; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n_done++;
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_bin", 32'(bus.bin), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
    chk("midrst_state", 32'(bus.state), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);
    run_conv(4'd0, 4'd0, 4'd1, 4'd0, 1'b0);

    // Start held high through DONE is taken in the following IDLE cycle
    bus.bcd3 = 4'd5; bus.bcd2 = 4'd6; bus.bcd1 = 4'd7; bus.bcd0 = 4'd8;
    bus.start = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n_done++;
      if (c == 15) begin
        chk("held_done1", 32'(bus.done), 32'd1);
        chk("held_bin1", 32'(bus.bin), 32'd5678);
        bus.bcd3 = 4'd0; bus.bcd2 = 4'd0; bus.bcd1 = 4'd9; bus.bcd0 = 4'd9;
      end
      if (c == 16) begin
        chk("held_idle_busy", 32'(bus.busy), 32'd0);
        chk("held_idle_done", 32'(bus.done), 32'd0);
      end
      if (c == 17) begin
        chk("held_rebusy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
      end
      if (c == 31) begin
        chk("held_done2", 32'(bus.done), 32'd1);
        chk("held_bin2", 32'(bus.bin), 32'd99);
      end
    end
    chk("held_done_count", 32'(n_done), 32'd2);

    // Strided sweep across the whole valid range
    for (int s = 0; s <= 9999; s += 37) begin
      run_conv(4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10), 1'b0);
    end

    // Random values, some with a corrupted digit, some with mid-conversion disturbance
    for (int k = 0; k < 800; k++) begin
      v = $urandom_range(0, 9999);
      d[3] = 4'(v / 1000);
      d[2] = 4'((v / 100) % 10);
      d[1] = 4'((v / 10) % 10);
      d[0] = 4'(v % 10);
      if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
      run_conv(d[3], d[2], d[1], d[0], 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
